// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the clock-enable generator.
//   state_e       : ALIGN / SETTLE / LOCKED controller states
//   ch_idx_w()    : width of a channel index, never less than 1
//   cfg_is_valid(): legality test for a configuration transfer
package clk_gen_pkg;

  typedef enum logic [1:0] {
    ALIGN  = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_e;

  function automatic int unsigned ch_idx_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Arguments are zero-extended to 64 bits by the caller.
  function automatic logic cfg_is_valid(input logic [63:0] ch,
                                        input logic [63:0] num_ch,
                                        input logic [63:0] div,
                                        input logic [63:0] phase);
    return (div != 64'd0) && (phase < div) && (ch < num_ch);
  endfunction

endpackage

// File: rtl/clk_gen_chan.sv
// One output channel: divide/phase registers, modulo counter, ce/sq decode.
//   refclk, rst  : clock, async active-high reset
//   align        : controller is in ALIGN this cycle (counter reloads phase)
//   wr           : accepted legal config addressed to this channel
//   out_en_nxt   : outputs are allowed next cycle (not ALIGN, gating applied)
//   cfg_div/phase: new divide ratio and phase offset
//   ce, sq       : registered enable pulse and square wave
module clk_gen_chan #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             align,
  input  logic             wr,
  input  logic             out_en_nxt,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             ce,
  output logic             sq
);

  logic [CNT_W-1:0] div_r;
  logic [CNT_W-1:0] phase_r;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] last;
  logic [CNT_W:0]   half;

  // Terminal count and high-time threshold; extra bit keeps D+1 from overflowing.
  assign last = div_r - 1'b1;
  assign half = ({1'b0, div_r} + 1'b1) >> 1;

  // Counter next value: reload phase in ALIGN, otherwise count modulo div_r.
  always_comb begin
    cnt_nxt = cnt;
    if (align) begin
      cnt_nxt = phase_r;
    end else if (cnt >= last) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // Outputs decode the next count so they line up with the counter value.
  // A write always coincides with out_en_nxt=0, so decoding against div_r is safe.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      div_r   <= CNT_W'(DEFAULT_DIV);
      phase_r <= '0;
      cnt     <= '0;
      ce      <= 1'b0;
      sq      <= 1'b0;
    end else begin
      if (wr) begin
        div_r   <= cfg_div;
        phase_r <= cfg_phase;
      end
      cnt <= cnt_nxt;
      ce  <= out_en_nxt && (cnt_nxt == last);
      sq  <= out_en_nxt && ({1'b0, cnt_nxt} < half);
    end
  end

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator with runtime divide/phase config and lock.
//   refclk, rst       : sole clock, async active-high reset
//   cfg_valid/ready   : config handshake (ready only in SETTLE/LOCKED)
//   cfg_ch/div/phase  : target channel, divide ratio, phase offset
//   cfg_err           : one-cycle pulse after a rejected transfer
//   ce, sq            : per-channel enable pulse and square wave
//   locked            : all channels aligned and settled
module clk_enable_gen
  import clk_gen_pkg::*;
#(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned DEFAULT_DIV   = 4,
  parameter int unsigned LOCK_CYCLES   = 16,
  parameter bit          GATE_UNLOCKED = 1'b1
) (
  input  logic                          refclk,
  input  logic                          rst,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]              cfg_div,
  input  logic [CNT_W-1:0]              cfg_phase,
  output logic                          cfg_err,
  output logic [NUM_CH-1:0]             ce,
  output logic [NUM_CH-1:0]             sq,
  output logic                          locked
);

  localparam int unsigned CH_W  = ch_idx_w(NUM_CH);
  localparam int unsigned SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  state_e           state;
  state_e           state_nxt;
  logic [SET_W-1:0] settle_cnt;
  logic [SET_W-1:0] settle_cnt_nxt;
  logic             xfer;
  logic             cfg_ok;
  logic             wr;
  logic             out_en_nxt;

  assign xfer   = cfg_valid && cfg_ready;
  assign cfg_ok = cfg_is_valid(64'(cfg_ch), 64'(NUM_CH), 64'(cfg_div), 64'(cfg_phase));
  assign wr     = xfer && cfg_ok;

  // Next state and settle count; a legal write overrides everything and realigns.
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    unique case (state)
      ALIGN: begin
        state_nxt      = SETTLE;
        settle_cnt_nxt = '0;
      end
      SETTLE: begin
        if (settle_cnt == SET_W'(LOCK_CYCLES - 1)) begin
          state_nxt = LOCKED;
        end else begin
          settle_cnt_nxt = settle_cnt + 1'b1;
        end
      end
      LOCKED: begin
        state_nxt = LOCKED;
      end
      default: begin
        state_nxt = ALIGN;
      end
    endcase
    if (wr) begin
      state_nxt      = ALIGN;
      settle_cnt_nxt = '0;
    end
  end

  assign out_en_nxt = (state_nxt != ALIGN) && (!GATE_UNLOCKED || (state_nxt == LOCKED));

  // State register and registered status outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= ALIGN;
      settle_cnt <= '0;
      cfg_ready  <= 1'b0;
      cfg_err    <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      cfg_ready  <= (state_nxt != ALIGN);
      cfg_err    <= xfer && !cfg_ok;
      locked     <= (state_nxt == LOCKED);
    end
  end

  // Channels share the ALIGN strobe so every counter restarts on the same edge.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_gen_chan #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .refclk    (refclk),
      .rst       (rst),
      .align     (state == ALIGN),
      .wr        (wr && (cfg_ch == CH_W'(i))),
      .out_en_nxt(out_en_nxt),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .ce        (ce[i]),
      .sq        (sq[i])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: a gated (A) and an ungated (B) instance share stimulus.
// A timing-formula model predicts every cycle into a scoreboard queue; feature
// tasks add targeted inline checks.
module tb_clk_enable_gen;

  localparam int unsigned NCH = 3;
  localparam int unsigned LK  = 16;

  logic        refclk    = 1'b0;
  logic        rst       = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_ch    = '0;
  logic [15:0] cfg_div   = '0;
  logic [15:0] cfg_phase = '0;

  logic       ready_a, err_a, locked_a;
  logic       ready_b, err_b, locked_b;
  logic [2:0] ce_a, sq_a, ce_b, sq_b;

  always #5 refclk = ~refclk;

  clk_enable_gen #(
    .NUM_CH(NCH), .CNT_W(16), .DEFAULT_DIV(4), .LOCK_CYCLES(LK), .GATE_UNLOCKED(1'b1)
  ) dut_a (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(ready_a),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(err_a),
    .ce(ce_a), .sq(sq_a), .locked(locked_a)
  );

  clk_enable_gen #(
    .NUM_CH(NCH), .CNT_W(16), .DEFAULT_DIV(4), .LOCK_CYCLES(LK), .GATE_UNLOCKED(1'b0)
  ) dut_b (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(ready_b),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(err_b),
    .ce(ce_b), .sq(sq_b), .locked(locked_b)
  );

  typedef struct packed {
    logic [2:0] ce_a;
    logic [2:0] sq_a;
    logic [2:0] ce_b;
    logic [2:0] sq_b;
    logic       locked;
    logic       err;
    logic       ready;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   t0     = 0;
  int   m_div[3];
  int   m_phase[3];
  logic m_err  = 1'b0;

  function automatic exp_t model_exp();
    exp_t e;
    int   rel;
    int   cnt;
    e   = '0;
    rel = cyc - t0;
    if (rst || rel < 1) return e;
    e.ready  = 1'b1;
    e.err    = m_err;
    e.locked = (rel >= LK + 1);
    for (int n = 0; n < 3; n++) begin
      cnt       = (m_phase[n] + rel - 1) % m_div[n];
      e.ce_b[n] = (cnt == m_div[n] - 1);
      e.sq_b[n] = (cnt < (m_div[n] + 1) / 2);
      e.ce_a[n] = e.ce_b[n] && e.locked;
      e.sq_a[n] = e.sq_b[n] && e.locked;
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 3; n++) begin
      m_div[n]   = 4;
      m_phase[n] = 0;
    end
    m_err = 1'b0;
  endtask

  // One clock: predict handshake, advance model, push expectation, pop and compare.
  task automatic step();
    exp_t e;
    exp_t got;
    logic hs;
    logic ok;
    int   rel;
    rel = cyc - t0;
    hs  = cfg_valid && !rst && (rel >= 1);
    ok  = (cfg_div != 16'd0) && (cfg_phase < cfg_div) && (cfg_ch < 2'(NCH));
    @(posedge refclk);
    cyc++;
    m_err = 1'b0;
    if (!rst && hs) begin
      if (ok) begin
        m_div[cfg_ch]   = int'(cfg_div);
        m_phase[cfg_ch] = int'(cfg_phase);
        t0 = cyc;
      end else begin
        m_err = 1'b1;
      end
    end
    sb_q.push_back(model_exp());
    #1;
    e   = sb_q.pop_front();
    got = {ce_a, sq_a, ce_b, sq_b, locked_a, err_a, ready_a};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL sb_a cyc=%0d got=%b exp=%b", cyc, got, e);
    end
    checks++;
    if ({locked_b, err_b, ready_b} !== {e.locked, e.err, e.ready}) begin
      errors++;
      $display("FAIL sb_b_status cyc=%0d got=%b exp=%b", cyc,
               {locked_b, err_b, ready_b}, {e.locked, e.err, e.ready});
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({ce_a, sq_a, ce_b, sq_b, locked_a, err_a, ready_a} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0", {ce_a, sq_a, ce_b, sq_b, locked_a, err_a, ready_a});
    end
    step();
    step();
    rst = 1'b0;
    t0  = cyc;
    for (int r = 1; r <= 28; r++) begin
      step();
      checks++;
      if (ce_a[0] !== (r == 20 || r == 24 || r == 28)) begin
        errors++;
        $display("FAIL reset_ce0 rel=%0d got=%b exp=%b", r, ce_a[0], (r == 20 || r == 24 || r == 28));
      end
      if (r >= 17) begin
        checks++;
        if (sq_a[0] !== (((r - 1) % 4) < 2)) begin
          errors++;
          $display("FAIL reset_sq0 rel=%0d got=%b exp=%b", r, sq_a[0], (((r - 1) % 4) < 2));
        end
      end
      if (r == 16 || r == 17) begin
        checks++;
        if (locked_a !== (r == 17)) begin
          errors++;
          $display("FAIL reset_lock rel=%0d got=%b exp=%b", r, locked_a, (r == 17));
        end
      end
    end
  endtask

  task automatic test_reconfig();
    cfg_ch = 2'd1; cfg_div = 16'd6; cfg_phase = 16'd2; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    checks++;
    if ({locked_a, locked_b} !== 2'b00) begin
      errors++;
      $display("FAIL reconfig_unlock got=%b exp=00", {locked_a, locked_b});
    end
    for (int k = 2; k <= 18; k++) begin
      step();
      if (k == 5 || k == 11) begin
        checks++;
        if (ce_b[1] !== 1'b1) begin
          errors++;
          $display("FAIL reconfig_ce1 h+%0d got=%b exp=1", k, ce_b[1]);
        end
      end
      if (k == 17 || k == 18) begin
        checks++;
        if (locked_a !== (k == 18)) begin
          errors++;
          $display("FAIL reconfig_lock h+%0d got=%b exp=%b", k, locked_a, (k == 18));
        end
      end
    end
  endtask

  task automatic test_invalid();
    logic [1:0]  chs [3];
    logic [15:0] dvs [3];
    logic [15:0] phs [3];
    chs[0] = 2'd0; dvs[0] = 16'd6; phs[0] = 16'd6;
    chs[1] = 2'd0; dvs[1] = 16'd0; phs[1] = 16'd0;
    chs[2] = 2'd3; dvs[2] = 16'd4; phs[2] = 16'd0;
    for (int i = 0; i < 3; i++) begin
      cfg_ch = chs[i]; cfg_div = dvs[i]; cfg_phase = phs[i]; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      checks++;
      if ({err_a, err_b, locked_a} !== 3'b111) begin
        errors++;
        $display("FAIL invalid_err case=%0d got=%b exp=111", i, {err_a, err_b, locked_a});
      end
      step();
      checks++;
      if ({err_a, err_b, locked_a} !== 3'b001) begin
        errors++;
        $display("FAIL invalid_err_clear case=%0d got=%b exp=001", i, {err_a, err_b, locked_a});
      end
      step();
    end
  endtask

  task automatic test_div1();
    cfg_ch = 2'd2; cfg_div = 16'd1; cfg_phase = 16'd0; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int k = 2; k <= 18; k++) step();
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if ({ce_a[2], sq_a[2], ce_b[2], sq_b[2]} !== 4'b1111) begin
        errors++;
        $display("FAIL div1 k=%0d got=%b exp=1111", k, {ce_a[2], sq_a[2], ce_b[2], sq_b[2]});
      end
    end
  endtask

  task automatic test_valid_hold();
    cfg_ch = 2'd0; cfg_div = 16'd5; cfg_phase = 16'd1; cfg_valid = 1'b1;
    step();
    checks++;
    if ({ready_a, ready_b} !== 2'b00) begin
      errors++;
      $display("FAIL hold_ready_align got=%b exp=00", {ready_a, ready_b});
    end
    step();
    checks++;
    if ({ready_a, locked_a} !== 2'b10) begin
      errors++;
      $display("FAIL hold_ready_settle got=%b exp=10", {ready_a, locked_a});
    end
    step();
    cfg_valid = 1'b0;
    for (int k = 4; k <= 20; k++) begin
      step();
      if (k == 19 || k == 20) begin
        checks++;
        if (locked_a !== (k == 20)) begin
          errors++;
          $display("FAIL hold_lock h+%0d got=%b exp=%b", k, locked_a, (k == 20));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({ce_a, sq_a, ce_b, sq_b, locked_a, locked_b, err_a, err_b, ready_a, ready_b} !== 18'd0) begin
      errors++;
      $display("FAIL async_rst_outputs got=%b exp=0",
               {ce_a, sq_a, ce_b, sq_b, locked_a, locked_b, err_a, err_b, ready_a, ready_b});
    end
    step();
    step();
    rst = 1'b0;
    t0  = cyc;
    for (int r = 1; r <= 20; r++) begin
      step();
      if (r == 8 || r == 9) begin
        checks++;
        if ({ce_b[0], ce_b[1], ce_b[2]} !== {3{r == 8}}) begin
          errors++;
          $display("FAIL async_rst_div rel=%0d got=%b exp=%b", r, {ce_b[0], ce_b[1], ce_b[2]}, {3{r == 8}});
        end
      end
      if (r == 16 || r == 17) begin
        checks++;
        if (locked_a !== (r == 17)) begin
          errors++;
          $display("FAIL async_rst_lock rel=%0d got=%b exp=%b", r, locked_a, (r == 17));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reconfig();
    test_invalid();
    test_div1();
    test_valid_hold();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
